mips_prog_loader: RTL and testbench
===================================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width of the target 1024 x 32 instruction/data memory.
REQ-002 Parameter: SYNC, default 8'hA5, frame start byte.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid & in_ready at posedge clk.
REQ-008 mem_we  output  1  one-cycle memory write strobe.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  write data.
REQ-011 busy  output  1  frame in progress (any state except IDLE).
REQ-012 done  output  1  sticky: last frame loaded with a good checksum.
REQ-013 error  output  1  sticky: last frame aborted (bad count or bad checksum).
REQ-014 cpu_start  output  1  one-cycle pulse releasing the processor (drives the processor's PC=0 and HALTED=0 load).
REQ-015 word_count  output  ADDR_W+1  number of words written in the current/last frame.

Function
REQ-016 Frame format: SYNC, CNT_H, CNT_L (16-bit word count N, big-endian), 4N payload bytes, CHK (XOR of all 4N payload bytes).
REQ-017 Payload words are big-endian: the first byte is mem_wdata[31:24]; word k is written to mem_addr = k, with k = 0..N-1.
REQ-018 State machine: IDLE, CNT_H, CNT_L, DATA, WRITE, CHK.
REQ-019 IDLE: accepted bytes other than SYNC are discarded; accepting SYNC -> CNT_H and clears done, error, word_count, the checksum accumulator, and the byte/word counters.
REQ-020 CNT_H -> CNT_L -> DATA on each accepted byte; N is latched from these two bytes.
REQ-021 At the transition out of CNT_L, N = 0 or N > 2**ADDR_W sets error and returns to IDLE; no memory write occurs.
REQ-022 DATA: each accepted byte shifts into a 32-bit assembly register and is XORed into the checksum; the 4th byte of a word -> WRITE.
REQ-023 WRITE: lasts exactly one cycle, with mem_we=1, mem_addr=k, mem_wdata=the assembled word, and in_ready=0; word_count increments; -> CHK if k = N-1, else -> DATA.
REQ-024 mem_we is 0 in every state other than WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-025 in_ready=1 in IDLE, CNT_H, CNT_L, DATA and CHK; in_ready=0 in WRITE and during reset.
REQ-026 CHK: an accepted byte equal to the accumulator sets done and pulses cpu_start on the next cycle; an unequal byte sets error with no cpu_start. Both cases -> IDLE.
REQ-027 Latency: cpu_start is asserted exactly one cycle after the CHK byte transfer, for one cycle only.
REQ-028 in_valid=0 in any state holds that state indefinitely; there is no timeout.
REQ-029 SYNC bytes inside CNT_H, CNT_L, DATA or CHK are treated as ordinary data (no resynchronisation).
REQ-030 Words already written remain in memory if a frame is later aborted by a bad checksum.
REQ-031 The address counter must not wrap: the maximum frame N = 1024 writes addresses 0..1023 exactly once.

Reset
REQ-032 rst=1 asynchronously forces IDLE with in_ready=0, mem_we=0, busy=0, done=0, error=0, cpu_start=0, word_count=0, and all counters and the accumulator at 0.
REQ-033 rst asserted mid-frame (including during WRITE) abandons the frame immediately; no further write occurs, and after rst deasserts the loader waits for a new SYNC.
REQ-034 in_ready rises on the first posedge clk after rst deasserts.

Verification
REQ-035 Stream A5 00 02 28 01 00 0A 28 02 00 14 (CHK = XOR of the 8 payload bytes) -> writes Mem[0]=32'h2801000A and Mem[1]=32'h28020014; word_count=2; done=1; one cpu_start pulse; error=0.
REQ-036 Same frame with the CHK byte XORed with 8'h01 -> both words written; error=1; done=0; no cpu_start.
REQ-037 Leading garbage 00 FF 5A, then a valid N=1 frame FC 00 00 00 -> garbage ignored; Mem[0]=32'hFC000000; done=1.
REQ-038 Count bytes 00 00, and separately 04 01 -> error=1 immediately after CNT_L, mem_we never asserted; the next valid frame loads normally.
REQ-039 N=1024 frame with in_valid toggled randomly -> all 1024 addresses written once in order; in_ready=0 on every WRITE cycle; no byte lost or duplicated.
REQ-040 rst pulsed after 6 payload bytes of an N=3 frame -> exactly one write (Mem[0]); all outputs reset; a subsequent frame completes with done=1.

Source files
------------

// File: rtl/mips_prog_loader_if.sv
// Byte-stream ingress and memory-write egress bundle for the MIPS program loader.
// The master modport is the loader side; the slave modport is the stream source, memory and CPU side.
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_start;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, done, error, cpu_start, word_count
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, done, error, cpu_start, word_count
  );

endinterface

// File: rtl/mips_prog_loader.sv
// Loads a framed byte stream (SYNC, 16-bit count, big-endian words, XOR checksum)
// into instruction memory, then pulses cpu_start when the checksum matches.
module mips_prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  mips_prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_DATA,
    S_WRITE,
    S_CHK
  } state_t;

  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_start_q, cpu_start_d;

  logic              accept;
  logic [15:0]       n_new;
  logic [16:0]       wc_inc;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    chk_d        = chk_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = done_q;
    error_d      = error_q;
    cpu_start_d  = 1'b0;
    accept       = bus.in_valid && in_ready_q;
    n_new        = {n_q[15:8], bus.in_data};
    wc_inc       = 17'(word_count_q) + 17'd1;

    case (state_q)
      S_IDLE: begin
        if (accept && (bus.in_data == SYNC)) begin
          state_d      = S_CNT_H;
          done_d       = 1'b0;
          error_d      = 1'b0;
          word_count_d = '0;
          chk_d        = '0;
          byte_cnt_d   = '0;
          asm_d        = '0;
        end
      end
      S_CNT_H: begin
        if (accept) begin
          n_d     = {bus.in_data, n_q[7:0]};
          state_d = S_CNT_L;
        end
      end
      S_CNT_L: begin
        if (accept) begin
          n_d = n_new;
          // A zero-length frame or one larger than the memory is rejected before any write.
          if ((n_new == 16'd0) || ({1'b0, n_new} > MAX_N)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], bus.in_data};
          chk_d      = chk_q ^ bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_addr_d  = word_count_q[ADDR_W-1:0];
            mem_wdata_d = {asm_q, bus.in_data};
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        state_d      = (wc_inc == {1'b0, n_q}) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == chk_q) begin
            done_d      = 1'b1;
            cpu_start_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake and strobe outputs are registered, so they follow the next state.
    in_ready_d = (state_d != S_WRITE);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      chk_q        <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      chk_q        <= chk_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_start_q  <= cpu_start_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.cpu_start  = cpu_start_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomised frame-level bench for mips_prog_loader with a byte/word-level reference model.
module tb_mips_prog_loader;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;

  logic [31:0]       words [1024];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  int                pulse_cnt = 0;

  int  exp_nwr;
  int  exp_wc;
  bit  exp_done;
  bit  exp_error;
  int  exp_pulses;

  // Observed writes and cpu_start cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_in_ready: in_ready=%b during write, expected 0", bus.in_ready);
      end
    end
    if (bus.cpu_start === 1'b1) pulse_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int budget;
    int g;
    @(negedge clk);
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        bus.in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after 100 cycles, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Reference outcome of a frame, from the frame rules alone.
  task automatic model_frame(input logic [15:0] n, input bit bad);
    bit valid;
    valid      = (n != 16'd0) && (int'(n) <= 1024);
    exp_nwr    = valid ? int'(n) : 0;
    exp_wc     = valid ? int'(n) : 0;
    exp_done   = valid && !bad;
    exp_error  = !valid || bad;
    exp_pulses = exp_done ? 1 : 0;
  endtask

  task automatic send_frame(input logic [15:0] n, input bit bad);
    logic [7:0] chk;
    logic [7:0] b;
    chk = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    pulse_cnt = 0;
    model_frame(n, bad);
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (exp_nwr > 0) begin
      for (int k = 0; k < int'(n); k++) begin
        for (int j = 3; j >= 0; j--) begin
          b   = words[k][8*j +: 8];
          chk = chk ^ b;
          send_byte(b);
        end
      end
      send_byte(chk ^ {7'b0, bad});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if ({bus.busy, bus.done, bus.error, bus.cpu_start} !== 4'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 0000", {bus.busy, bus.done, bus.error, bus.cpu_start}); end
    checks++; if (bus.word_count !== '0) begin errors++; $display("[TB] FAIL rst_word_count: got %0d expected 0", bus.word_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_in_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    words[0] = 32'h2801000A;
    words[1] = 32'h28020014;
    gaps = 1'b0;
    send_frame(16'd2, 1'b0);
    checks++; if (bus.cpu_start !== 1'b1) begin errors++; $display("[TB] FAIL dir_cpu_start_rise: got %b expected 1", bus.cpu_start); end
    checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("[TB] FAIL dir_done_error: got %b%b expected 10", bus.done, bus.error); end
    @(posedge clk); #1;
    checks++; if (bus.cpu_start !== 1'b0) begin errors++; $display("[TB] FAIL dir_cpu_start_fall: got %b expected 0", bus.cpu_start); end
    repeat (2) @(negedge clk);
    checks++; if (wr_data.size() != 2) begin errors++; $display("[TB] FAIL dir_nwrites: got %0d expected 2", wr_data.size()); end
    else begin
      checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h2801000A) begin errors++; $display("[TB] FAIL dir_word0: got %0d:%h expected 0:2801000a", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h28020014) begin errors++; $display("[TB] FAIL dir_word1: got %0d:%h expected 1:28020014", wr_addr[1], wr_data[1]); end
    end
    checks++; if (bus.word_count !== 11'd2) begin errors++; $display("[TB] FAIL dir_word_count: got %0d expected 2", bus.word_count); end
    checks++; if (pulse_cnt != 1) begin errors++; $display("[TB] FAIL dir_pulses: got %0d expected 1", pulse_cnt); end
  endtask

  task automatic test_bad_checksum;
    words[0] = 32'h2801000A;
    words[1] = 32'h28020014;
    send_frame(16'd2, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (wr_data.size() != 2) begin errors++; $display("[TB] FAIL badchk_nwrites: got %0d expected 2", wr_data.size()); end
    checks++; if (bus.done !== 1'b0 || bus.error !== 1'b1) begin errors++; $display("[TB] FAIL badchk_done_error: got %b%b expected 01", bus.done, bus.error); end
    checks++; if (pulse_cnt != 0) begin errors++; $display("[TB] FAIL badchk_pulses: got %0d expected 0", pulse_cnt); end
  endtask

  task automatic test_garbage;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL garbage_busy: got %b expected 0", bus.busy); end
    words[0] = 32'hFC000000;
    send_frame(16'd1, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'hFC000000 || wr_addr[0] !== 10'd0) begin
      errors++; $display("[TB] FAIL garbage_write: got %0d writes first %h expected 1 write fc000000 at 0", wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL garbage_done: got %b expected 1", bus.done); end
  endtask

  task automatic test_bad_count;
    logic [15:0] bad_n [2];
    bad_n[0] = 16'h0000;
    bad_n[1] = 16'h0401;
    for (int i = 0; i < 2; i++) begin
      send_frame(bad_n[i], 1'b0);
      #1;
      checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL badcnt_error_%0d: got err=%b busy=%b expected err=1 busy=0", i, bus.error, bus.busy); end
      repeat (4) @(negedge clk);
      checks++; if (wr_data.size() != 0) begin errors++; $display("[TB] FAIL badcnt_writes_%0d: got %0d expected 0", i, wr_data.size()); end
    end
    words[0] = 32'h12345678;
    words[1] = 32'hA5A5A5A5;
    send_frame(16'd2, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || wr_data.size() != 2) begin errors++; $display("[TB] FAIL badcnt_recover: got done=%b writes=%0d expected done=1 writes=2", bus.done, wr_data.size()); end
  endtask

  task automatic test_random_frames;
    logic [15:0] n;
    bit bad;
    gaps = 1'b1;
    for (int f = 0; f < 8; f++) begin
      n   = 16'($urandom_range(1, 8));
      bad = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) words[k] = $urandom;
      words[0][31:24] = 8'hA5;
      send_frame(n, bad);
      repeat (3) @(negedge clk);
      checks++; if (wr_data.size() != exp_nwr) begin errors++; $display("[TB] FAIL rnd_nwrites_%0d: got %0d expected %0d", f, wr_data.size(), exp_nwr); end
      else begin
        for (int k = 0; k < exp_nwr; k++) begin
          checks++;
          if (int'(wr_addr[k]) != k || wr_data[k] !== words[k]) begin
            errors++; $display("[TB] FAIL rnd_word_%0d_%0d: got %0d:%h expected %0d:%h", f, k, wr_addr[k], wr_data[k], k, words[k]);
          end
        end
      end
      checks++; if (bus.done !== exp_done || bus.error !== exp_error) begin errors++; $display("[TB] FAIL rnd_flags_%0d: got %b%b expected %b%b", f, bus.done, bus.error, exp_done, exp_error); end
      checks++; if (int'(bus.word_count) != exp_wc) begin errors++; $display("[TB] FAIL rnd_word_count_%0d: got %0d expected %0d", f, bus.word_count, exp_wc); end
      checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("[TB] FAIL rnd_pulses_%0d: got %0d expected %0d", f, pulse_cnt, exp_pulses); end
    end
    gaps = 1'b0;
  endtask

  task automatic test_max_frame;
    int bad_words;
    gaps = 1'b1;
    for (int k = 0; k < 1024; k++) words[k] = $urandom;
    send_frame(16'd1024, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (wr_data.size() != 1024) begin errors++; $display("[TB] FAIL max_nwrites: got %0d expected 1024", wr_data.size()); end
    else begin
      bad_words = 0;
      for (int k = 0; k < 1024; k++)
        if (int'(wr_addr[k]) != k || wr_data[k] !== words[k]) bad_words++;
      checks++; if (bad_words != 0) begin errors++; $display("[TB] FAIL max_words: got %0d wrong words expected 0", bad_words); end
    end
    checks++; if (bus.word_count !== 11'd1024) begin errors++; $display("[TB] FAIL max_word_count: got %0d expected 1024", bus.word_count); end
    checks++; if (bus.done !== 1'b1 || pulse_cnt != 1) begin errors++; $display("[TB] FAIL max_done: got done=%b pulses=%0d expected 1/1", bus.done, pulse_cnt); end
    gaps = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    for (int k = 0; k < 3; k++) words[k] = $urandom;
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(words[i / 4][8*(3 - (i % 4)) +: 8]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_start} !== 6'b0 || bus.word_count !== '0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got %b wc=%0d expected 000000 wc=0", {bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_start}, bus.word_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (wr_data.size() != 1 || wr_data[0] !== words[0]) begin errors++; $display("[TB] FAIL midrst_writes: got %0d writes expected 1 of %h", wr_data.size(), words[0]); end

    // Reset landing on the WRITE cycle itself must suppress that write.
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 4; i++) send_byte(words[0][8*(3 - i) +: 8]);
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wrrst_mem_we: got %b expected 0", bus.mem_we); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_data.size() != 0) begin errors++; $display("[TB] FAIL wrrst_writes: got %0d expected 0", wr_data.size()); end

    send_frame(16'd3, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || wr_data.size() != 3) begin errors++; $display("[TB] FAIL midrst_recover: got done=%b writes=%0d expected 1/3", bus.done, wr_data.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_checksum();
    test_garbage();
    test_bad_count();
    test_random_frames();
    test_max_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
